// File: rtl/cdr_loop_gain_scheduler.sv
// CDR loop-filter sequencer: windowed Up/Dn vote counting, acquisition/tracking gain
// scheduling, loop-filter clear on (re)start and lock reporting.
module cdr_loop_gain_scheduler #(
  parameter int WIN_LOG2   = 6,
  parameter int LOCK_THR   = 4,
  parameter int LOCK_WINS  = 4,
  parameter int UNLOCK_THR = 16,
  parameter int GW         = 5,
  parameter int ACQ_GAIN   = 6,
  parameter int ACQ_FRUG   = 16,
  parameter int TRK_GAIN   = 3,
  parameter int TRK_FRUG   = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          Up,
  input  logic          Dn,
  output logic [GW-1:0] phase_gain,
  output logic [GW-1:0] freq_gain,
  output logic          freq_hold,
  output logic          lf_clr,
  output logic          locked,
  output logic [1:0]    state
);

  localparam int NW = WIN_LOG2 + 2;
  localparam logic [NW-1:0] LOCK_LIM   = NW'(LOCK_THR);
  localparam logic [NW-1:0] UNLOCK_LIM = NW'(UNLOCK_THR);
  localparam logic [3:0]    LOCK_N     = 4'(LOCK_WINS);

  typedef enum logic [1:0] {
    S_OFF   = 2'b00,
    S_CLEAR = 2'b01,
    S_ACQ   = 2'b10,
    S_TRACK = 2'b11
  } state_t;

  state_t                 state_q, state_d;
  logic [WIN_LOG2-1:0]    win_cnt_q, win_cnt_d;
  logic signed [NW-1:0]   net_q, net_d;
  logic [3:0]             quiet_cnt_q, quiet_cnt_d;
  logic [GW-1:0]          phase_gain_d, freq_gain_d;
  logic                   freq_hold_d, lf_clr_d, locked_d;

  logic signed [NW-1:0]   vote;
  logic signed [NW-1:0]   net_eval;
  logic [NW-1:0]          net_mag;
  logic                   counting, win_end, quiet, loud;

  function automatic logic signed [NW-1:0] vote_of(input logic up, input logic dn);
    logic signed [NW-1:0] v;
    v = '0;
    if (up && !dn) v = {{(NW-1){1'b0}}, 1'b1};
    else if (dn && !up) v = '1;
    return v;
  endfunction

  function automatic logic [NW-1:0] mag(input logic signed [NW-1:0] x);
    logic [NW-1:0] r;
    r = x[NW-1] ? $unsigned(-x) : $unsigned(x);
    return r;
  endfunction

  // Window evaluation uses the net count including the current cycle's vote.
  always_comb begin
    counting = (state_q == S_ACQ) || (state_q == S_TRACK);
    vote     = vote_of(Up, Dn);
    net_eval = net_q + vote;
    net_mag  = mag(net_eval);
    win_end  = counting && (win_cnt_q == '1);
    quiet    = (net_mag <= LOCK_LIM);
    loud     = (net_mag > UNLOCK_LIM);

    state_d     = state_q;
    quiet_cnt_d = quiet_cnt_q;
    case (state_q)
      S_OFF:   state_d = S_CLEAR;
      S_CLEAR: state_d = S_ACQ;
      S_ACQ: begin
        if (win_end) begin
          if (quiet) begin
            quiet_cnt_d = quiet_cnt_q + 4'd1;
            if (quiet_cnt_q + 4'd1 == LOCK_N) state_d = S_TRACK;
          end else begin
            quiet_cnt_d = '0;
          end
        end
      end
      S_TRACK: begin
        if (win_end && loud) state_d = S_CLEAR;
      end
      default: state_d = S_OFF;
    endcase
    if (!en) state_d = S_OFF;

    // Counters only run while staying within ACQ/TRACK; any exit or restart clears them.
    if (counting && ((state_d == S_ACQ) || (state_d == S_TRACK))) begin
      win_cnt_d = win_cnt_q + WIN_LOG2'(1);
      net_d     = win_end ? '0 : net_eval;
    end else begin
      win_cnt_d   = '0;
      net_d       = '0;
      quiet_cnt_d = '0;
    end
  end

  always_comb begin
    phase_gain_d = '0;
    freq_gain_d  = '0;
    freq_hold_d  = 1'b1;
    lf_clr_d     = 1'b0;
    locked_d     = 1'b0;
    case (state_d)
      S_CLEAR: begin
        phase_gain_d = GW'(ACQ_GAIN);
        freq_gain_d  = GW'(ACQ_FRUG);
        lf_clr_d     = 1'b1;
      end
      S_ACQ: begin
        phase_gain_d = GW'(ACQ_GAIN);
        freq_gain_d  = GW'(ACQ_FRUG);
        freq_hold_d  = 1'b0;
      end
      S_TRACK: begin
        phase_gain_d = GW'(TRK_GAIN);
        freq_gain_d  = GW'(TRK_FRUG);
        freq_hold_d  = 1'b0;
        locked_d     = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_OFF;
      win_cnt_q   <= '0;
      net_q       <= '0;
      quiet_cnt_q <= '0;
      phase_gain  <= '0;
      freq_gain   <= '0;
      freq_hold   <= 1'b1;
      lf_clr      <= 1'b0;
      locked      <= 1'b0;
    end else begin
      state_q     <= state_d;
      win_cnt_q   <= win_cnt_d;
      net_q       <= net_d;
      quiet_cnt_q <= quiet_cnt_d;
      phase_gain  <= phase_gain_d;
      freq_gain   <= freq_gain_d;
      freq_hold   <= freq_hold_d;
      lf_clr      <= lf_clr_d;
      locked      <= locked_d;
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_cdr_loop_gain_scheduler.sv
// Self-checking bench for cdr_loop_gain_scheduler: directed scenarios plus randomized
// Up/Dn traffic against a cycle-level behavioural model of the windowed lock rules.
module tb_cdr_loop_gain_scheduler;

  logic       clk = 1'b0;
  logic       rst, en, Up, Dn;
  logic [4:0] phase_gain, freq_gain;
  logic       freq_hold, lf_clr, locked;
  logic [1:0] state;
  logic [14:0] dut_vec;

  int n_cmp  = 0;
  int n_fail = 0;

  localparam int WIN = 64;
  // {state, phase_gain, freq_gain, freq_hold, lf_clr, locked}
  localparam logic [14:0] V_OFF   = {2'd0, 5'd0,  5'd0,  1'b1, 1'b0, 1'b0};
  localparam logic [14:0] V_CLEAR = {2'd1, 5'd6,  5'd16, 1'b1, 1'b1, 1'b0};
  localparam logic [14:0] V_ACQ   = {2'd2, 5'd6,  5'd16, 1'b0, 1'b0, 1'b0};
  localparam logic [14:0] V_TRACK = {2'd3, 5'd3,  5'd8,  1'b0, 1'b0, 1'b1};

  // Model state: 0=off 1=clear 2=acquire 3=track; votes summed per 64-cycle window.
  int m_mode, m_cnt, m_net, m_quiet;

  cdr_loop_gain_scheduler dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .Up         (Up),
    .Dn         (Dn),
    .phase_gain (phase_gain),
    .freq_gain  (freq_gain),
    .freq_hold  (freq_hold),
    .lf_clr     (lf_clr),
    .locked     (locked),
    .state      (state)
  );

  assign dut_vec = {state, phase_gain, freq_gain, freq_hold, lf_clr, locked};

  always #5 clk = ~clk;

  function automatic logic [14:0] exp_vec(input int mode);
    case (mode)
      1:       return V_CLEAR;
      2:       return V_ACQ;
      3:       return V_TRACK;
      default: return V_OFF;
    endcase
  endfunction

  task automatic model_reset();
    m_mode = 0; m_cnt = 0; m_net = 0; m_quiet = 0;
  endtask

  task automatic model_step(input logic e, input logic u, input logic d);
    int a;
    if (!e) begin
      model_reset();
    end else begin
      case (m_mode)
        0: m_mode = 1;
        1: begin m_mode = 2; m_cnt = 0; m_net = 0; m_quiet = 0; end
        default: begin
          if (u && !d) m_net++;
          else if (d && !u) m_net--;
          m_cnt++;
          if (m_cnt == WIN) begin
            a = (m_net < 0) ? -m_net : m_net;
            m_cnt = 0;
            m_net = 0;
            if (m_mode == 2) begin
              if (a <= 4) begin
                m_quiet++;
                if (m_quiet == 4) m_mode = 3;
              end else begin
                m_quiet = 0;
              end
            end else if (a > 16) begin
              m_mode = 1;
            end
          end
        end
      endcase
    end
  endtask

  task automatic cyc(input logic e, input logic u, input logic d);
    en = e; Up = u; Dn = d;
    @(posedge clk);
    model_step(e, u, d);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; Up = 1'b0; Dn = 1'b0;
    model_reset();
    @(posedge clk); #1;
    n_cmp++;
    if (dut_vec !== V_OFF) begin
      n_fail++; $display("FAIL reset_vals: got %h want %h", dut_vec, V_OFF);
    end
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      cyc(1'b0, 1'b0, 1'b0);
      n_cmp++;
      if (dut_vec !== V_OFF) begin
        n_fail++; $display("FAIL idle_off cyc %0d: got %h want %h", i, dut_vec, V_OFF);
      end
    end
  endtask

  task automatic test_acquire_lock();
    int k;
    cyc(1'b1, 1'b0, 1'b0);
    n_cmp++;
    if (dut_vec !== V_CLEAR) begin
      n_fail++; $display("FAIL start_clear: got %h want %h", dut_vec, V_CLEAR);
    end
    cyc(1'b1, 1'b0, 1'b0);
    n_cmp++;
    if (dut_vec !== V_ACQ) begin
      n_fail++; $display("FAIL start_acq: got %h want %h", dut_vec, V_ACQ);
    end
    k = 0;
    while (locked !== 1'b1 && k < 1000) begin
      cyc(1'b1, 1'b0, 1'b0);
      k++;
      n_cmp++;
      if (dut_vec !== exp_vec(m_mode)) begin
        n_fail++; $display("FAIL acq_model cyc %0d: got %h want %h", k, dut_vec, exp_vec(m_mode));
      end
    end
    n_cmp++;
    if (k !== 256) begin
      n_fail++; $display("FAIL acq_lock_latency: got %0d want 256", k);
    end
    n_cmp++;
    if (dut_vec !== V_TRACK) begin
      n_fail++; $display("FAIL track_gains: got %h want %h", dut_vec, V_TRACK);
    end
  endtask

  task automatic test_quiet_reset();
    int k;
    cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0);
    n_cmp++;
    if (dut_vec !== V_ACQ) begin
      n_fail++; $display("FAIL qr_acq: got %h want %h", dut_vec, V_ACQ);
    end
    k = 0;
    while (locked !== 1'b1 && k < 1000) begin
      cyc(1'b1, (k < 192) && ((k % WIN) < 5), 1'b0);
      k++;
      n_cmp++;
      if (dut_vec !== exp_vec(m_mode)) begin
        n_fail++; $display("FAIL qr_model cyc %0d: got %h want %h", k, dut_vec, exp_vec(m_mode));
      end
    end
    n_cmp++;
    if (k !== 448) begin
      n_fail++; $display("FAIL qr_lock_latency: got %0d want 448", k);
    end
  endtask

  task automatic test_track_unlock();
    for (int k = 0; k < WIN; k++) begin
      cyc(1'b1, k < 16, 1'b0);
      n_cmp++;
      if (dut_vec !== exp_vec(m_mode)) begin
        n_fail++; $display("FAIL tu16_model cyc %0d: got %h want %h", k, dut_vec, exp_vec(m_mode));
      end
    end
    n_cmp++;
    if (dut_vec !== V_TRACK) begin
      n_fail++; $display("FAIL track_net16_stays: got %h want %h", dut_vec, V_TRACK);
    end
    for (int k = 0; k < WIN; k++) begin
      cyc(1'b1, k < 17, 1'b0);
      n_cmp++;
      if (dut_vec !== exp_vec(m_mode)) begin
        n_fail++; $display("FAIL tu17_model cyc %0d: got %h want %h", k, dut_vec, exp_vec(m_mode));
      end
    end
    n_cmp++;
    if (dut_vec !== V_CLEAR) begin
      n_fail++; $display("FAIL track_net17_relock: got %h want %h", dut_vec, V_CLEAR);
    end
    cyc(1'b1, 1'b0, 1'b0);
    n_cmp++;
    if (dut_vec !== V_ACQ) begin
      n_fail++; $display("FAIL relock_acq: got %h want %h", dut_vec, V_ACQ);
    end
  endtask

  task automatic test_both_votes();
    int k;
    logic u, d;
    k = 0;
    while (locked !== 1'b1 && k < 1000) begin
      u = (k < 64) || (k >= 64 && k < 68);
      d = (k < 64) || (k >= 128 && k < 132);
      cyc(1'b1, u, d);
      k++;
      n_cmp++;
      if (dut_vec !== exp_vec(m_mode)) begin
        n_fail++; $display("FAIL bv_model cyc %0d: got %h want %h", k, dut_vec, exp_vec(m_mode));
      end
    end
    n_cmp++;
    if (k !== 256) begin
      n_fail++; $display("FAIL both_votes_thr_lock: got %0d want 256", k);
    end
  endtask

  task automatic test_en_drop_and_reset();
    int k;
    for (int i = 0; i < 20; i++) cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    n_cmp++;
    if (dut_vec !== V_OFF) begin
      n_fail++; $display("FAIL en_drop_off: got %h want %h", dut_vec, V_OFF);
    end
    cyc(1'b1, 1'b0, 1'b0);
    n_cmp++;
    if (dut_vec !== V_CLEAR) begin
      n_fail++; $display("FAIL reenable_clear: got %h want %h", dut_vec, V_CLEAR);
    end
    cyc(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 30; i++) cyc(1'b1, 1'b0, 1'b0);
    #2 rst = 1'b1;
    model_reset();
    #1;
    n_cmp++;
    if (dut_vec !== V_OFF) begin
      n_fail++; $display("FAIL async_rst_vals: got %h want %h", dut_vec, V_OFF);
    end
    @(posedge clk); #1;
    en = 1'b1;
    rst = 1'b0;
    cyc(1'b1, 1'b0, 1'b0);
    n_cmp++;
    if (dut_vec !== V_CLEAR) begin
      n_fail++; $display("FAIL rst_release_clear: got %h want %h", dut_vec, V_CLEAR);
    end
    cyc(1'b1, 1'b0, 1'b0);
    k = 0;
    while (locked !== 1'b1 && k < 1000) begin
      cyc(1'b1, 1'b0, 1'b0);
      k++;
    end
    n_cmp++;
    if (k !== 256) begin
      n_fail++; $display("FAIL rst_no_partial_window: got %0d want 256", k);
    end
  endtask

  task automatic test_random();
    int   pat;
    logic e, u, d, prev_clr;
    pat = 0;
    prev_clr = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      if ((k % WIN) == 0) pat = $urandom_range(0, 3);
      e = ($urandom_range(0, 499) != 0);
      case (pat)
        0: begin u = 1'b0; d = 1'b0; end
        1: begin u = 1'($urandom_range(0, 1)); d = 1'($urandom_range(0, 1)); end
        2: begin u = ($urandom_range(0, 9) < 6); d = ($urandom_range(0, 9) < 3); end
        default: begin u = 1'b0; d = ($urandom_range(0, 9) < 4); end
      endcase
      cyc(e, u, d);
      n_cmp++;
      if (dut_vec !== exp_vec(m_mode)) begin
        n_fail++; $display("FAIL random_model cyc %0d: got %h want %h", k, dut_vec, exp_vec(m_mode));
      end
      n_cmp++;
      if (lf_clr === 1'b1 && prev_clr === 1'b1) begin
        n_fail++; $display("FAIL lf_clr_width cyc %0d: got 2 consecutive want 1", k);
      end
      prev_clr = lf_clr;
    end
  endtask

  initial begin
    test_reset();
    test_acquire_lock();
    test_quiet_reset();
    test_track_unlock();
    test_both_votes();
    test_en_drop_and_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
